// File: rtl/ahb_sram_resp.sv
// AHB-lite SRAM subordinate: sized/aligned accesses, lane-masked writes, WAIT_STATES data-phase stretch.
// Define AHB_SRAM_RESP_ERR_EN for illegal-access detection with the two-cycle ERROR response.

module ahb_sram_lane #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = 10
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);
    logic [7:0] mem [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module ahb_sram_resp #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  hsel_i,
    input  logic [DATA_WIDTH-1:0] haddr_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hready_o,
    output logic [1:0]            hresp_o
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    typedef struct packed {
        logic                 wr;
        logic [NUM_LANES-1:0] mask;
        logic [IDX_W-1:0]     idx;
    } req_t;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    req_t       req_q, req_d;
    logic       load;
    logic       accept;
    logic       last;
    logic       wr_fire;
    logic [1:0] accept_state;

    logic [DATA_WIDTH:0]   off_ext;
    logic [DATA_WIDTH-1:0] off;
    logic [NUM_LANES-1:0]  mask_d;

    logic [NUM_LANES-1:0][7:0] wdata_lanes;
    logic [NUM_LANES-1:0][7:0] rdata_lanes;

    // Borrow out of the extended subtraction flags haddr below BASE_ADDR.
    assign off_ext = {1'b0, haddr_i} - {1'b0, BASE_ADDR};
    assign off     = off_ext[DATA_WIDTH-1:0];
    assign last    = (cnt_q == 4'(WAIT_STATES));
    assign accept  = hsel_i & hready_o;

    // Halfword uses only haddr[1], word ignores [1:0]: this is the forced
    // natural alignment when error detection is compiled out.
    always_comb begin
        mask_d = '0;
        case (hsize_i)
            3'b000:  mask_d = 4'b0001 << haddr_i[1:0];
            3'b001:  mask_d = haddr_i[1] ? 4'b1100 : 4'b0011;
            default: mask_d = 4'b1111;
        endcase
    end

`ifdef AHB_SRAM_RESP_ERR_EN
    logic below, above, bad_size, misal, legal;
    logic unused_off;

    assign below    = off_ext[DATA_WIDTH];
    assign above    = {2'b00, off[DATA_WIDTH-1:2]} >= DATA_WIDTH'(MEM_WORDS);
    assign bad_size = hsize_i > 3'b010;
    assign misal    = (hsize_i == 3'b001 && haddr_i[0]) ||
                      (hsize_i == 3'b010 && |haddr_i[1:0]);
    assign legal    = !(below || above || bad_size || misal);
    assign accept_state = legal ? S_DATA : S_ERR1;
    assign unused_off   = ^off[1:0];
`else
    logic unused_off;

    assign accept_state = S_DATA;
    assign unused_off   = ^{off_ext[DATA_WIDTH], off[DATA_WIDTH-1:IDX_W+2], off[1:0]};
`endif

    assign req_d = '{wr: hwrite_i, mask: mask_d, idx: off[IDX_W+1:2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = accept_state;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            S_DATA: begin
                if (!last) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (accept) begin
                    state_d = accept_state;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef AHB_SRAM_RESP_ERR_EN
            S_ERR1: state_d = S_ERR2;
            S_ERR2: begin
                if (accept) begin
                    state_d = accept_state;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) req_q <= req_d;
        end
    end

    always_comb begin
        hready_o = 1'b1;
        hresp_o  = 2'b00;
        case (state_q)
            S_DATA: hready_o = last;
`ifdef AHB_SRAM_RESP_ERR_EN
            S_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = 2'b01;
            end
            S_ERR2: hresp_o = 2'b01;
`endif
            default: hready_o = 1'b1;
        endcase
    end

    // Reset in the final write cycle must drop the commit.
    assign wr_fire     = resetn_i && (state_q == S_DATA) && last && req_q.wr;
    assign wdata_lanes = hwdata_i;
    assign hrdata_o    = ((state_q == S_DATA) && last && !req_q.wr) ? rdata_lanes : '0;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ahb_sram_lane #(
            .MEM_WORDS(MEM_WORDS),
            .IDX_W    (IDX_W)
        ) u_lane (
            .clk_i(clk_i),
            .we   (wr_fire & req_q.mask[l]),
            .idx  (req_q.idx),
            .wdata(wdata_lanes[l]),
            .rdata(rdata_lanes[l])
        );
    end
endmodule

// File: doc/ahb_sram_resp.md
# ahb_sram_resp

AHB-lite subordinate that answers the transfers driven by the scalar/vector bus arbiter, backing them with an on-chip word-organised SRAM array. It decodes size and alignment, inserts a configurable number of wait states, performs byte/halfword/word writes with lane masking and returns full-word read data. When illegal accesses are detected, it signals the two-cycle AHB ERROR response. It sits on the core's AHB outputs, selected by the top-level address decoder.

## Interface
- DATA_WIDTH, 32, bus data/address width; only 32 supported
- MEM_WORDS, 1024, SRAM depth in 32-bit words; power of two
- BASE_ADDR, 32'h00000000, byte address of word 0; aligned to MEM_WORDS*4
- WAIT_STATES, 0, wait cycles (hready_o low) inserted per data phase; 0..15

- clk_i  in  1  clock; all logic on rising edge
- resetn_i  in  1  reset; synchronous, active-low
- hsel_i  in  1  slave select from address decoder
- haddr_i  in  DATA_WIDTH  byte address (address phase)
- hwrite_i  in  1  1 = write, 0 = read (address phase)
- hsize_i  in  3  3'b000 byte, 3'b001 halfword, 3'b010 word (address phase)
- hwdata_i  in  DATA_WIDTH  write data (data phase), little-endian lanes
- hrdata_o  out  DATA_WIDTH  read data (data phase)
- hready_o  out  1  data phase complete; also used as transfer-accept
- hresp_o  out  2  2'b00 OKAY, 2'b01 ERROR

## Operation
- Address phase accepted on a rising edge where hsel_i=1 and hready_o=1; haddr_i, hwrite_i, hsize_i latched. No htrans: every accepted cycle is a transfer.
- FSM states: IDLE (no data phase), DATA (data phase, wait counter running), ERR1, ERR2.
- IDLE: hready_o=1, hresp_o=OKAY, hrdata_o=0. Accept -> DATA (legal) or ERR1 (illegal), counter cleared.
- DATA: while counter < WAIT_STATES: hready_o=0, counter++. Final cycle: hready_o=1, OKAY; read -> hrdata_o = mem[word index]; write -> selected lanes of hwdata_i committed at the end of that cycle. Same-cycle accept of a new transfer is allowed (pipelined) -> DATA/ERR1 with the counter cleared; otherwise -> IDLE.
- Word index = (haddr - BASE_ADDR) >> 2. Lanes: byte = lane haddr[1:0]; halfword = lanes {haddr[1],0} and {haddr[1],1}; word = all four.
- Illegal: hsize > 3'b010; halfword with haddr[0]=1; word with haddr[1:0]≠0; (haddr - BASE_ADDR) ≥ MEM_WORDS*4 or haddr < BASE_ADDR. Illegal transfers never touch memory.
- ERR1: hready_o=0, hresp_o=ERROR, no accept -> ERR2. ERR2: hready_o=1, hresp_o=ERROR; an accept is allowed -> DATA/ERR1, else -> IDLE. Wait states are not applied to errors.
- hrdata_o is 0 in every cycle except the final cycle of a legal read; it carries the full aligned word.

## Timing
- Reset values: hready_o=1, hresp_o=2'b00, hrdata_o=0, state IDLE, counter 0. SRAM contents not reset.
- Read latency: data valid in the cycle after the address phase plus WAIT_STATES cycles.
- Write commit is visible to a read accepted in the same cycle as the write data phase (read data phase follows the commit edge).
- Back-to-back transfers at WAIT_STATES=0: one transfer per cycle, hready_o held 1.
- Reset asserted mid-transfer: the pending write is discarded; next cycle is IDLE with reset outputs.
- hsel_i=0 during DATA/ERR does not abort the data phase in progress.

## Configuration
- AHB_SRAM_RESP_ERR_EN defined: illegal-access detection and the ERR1/ERR2 response as above.
- Undefined: ERR states removed; hresp_o tied to OKAY; the word index wraps modulo MEM_WORDS; misaligned low address bits are cleared (access forced to natural alignment); hsize > 2 is treated as word.

## Test plan
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> hready_o stays 1, hrdata_o=0xDEADBEEF in the read data phase.
- Byte write 0xAA in lane 2 @0x12 over word 0x11223344 -> read @0x10 returns 0x11AA3344; halfword 0xBEEF @0x12 -> 0xBEEF3344.
- WAIT_STATES=3: read @0x0 -> hready_o low exactly 3 cycles, then high with data; address held stable by the bench.
- ERR_EN defined: word read @0x6 -> hready_o 0/ERROR, then 1/ERROR; memory unchanged; read @MEM_WORDS*4 -> same two-cycle ERROR.
- ERR_EN undefined: word write 0x12345678 @(MEM_WORDS*4 + 0x4) -> always OKAY; read @0x4 returns 0x12345678.
- resetn_i low during the write data phase at WAIT_STATES=2 -> write not committed, outputs return to reset values next cycle.
